mealy_control_matrix: RTL and testbench



---
 rtl/mealy_cm_pkg.sv | 18 +
 rtl/mealy_cm_decode.sv | 61 ++++++
 rtl/mealy_control_matrix.sv | 66 ++++++
 tb/tb_mealy_control_matrix.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mealy_cm_pkg.sv
// Shared types and constants for the reset/boot control matrix.
// State encodings are fixed because they are exposed on the optional debug port.
package mealy_cm_pkg;

  localparam int unsigned PC_SELECT_SIZE_DEF   = 3;
  localparam int unsigned ADDR_SELECT_SIZE_DEF = 2;

  localparam logic [PC_SELECT_SIZE_DEF-1:0]   PC_SRC_VECTOR = 3'd2;
  localparam logic [ADDR_SELECT_SIZE_DEF-1:0] ADDR_SRC_PC   = 2'd0;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_VECTOR = 2'd1,
    S_LD_MAR = 2'd2,
    S_HALT   = 2'd3
  } state_e;

endpackage : mealy_cm_pkg

// File: rtl/mealy_cm_decode.sv
// Combinational Mealy output decoder: (state, reset, hold) -> strobes and mux selects.
// Strobes are active-low; reset_i overrides the state so reset reaches the datapath immediately.
module mealy_cm_decode
  import mealy_cm_pkg::*;
#(
  parameter int unsigned                  PC_SELECT_SIZE   = PC_SELECT_SIZE_DEF,
  parameter int unsigned                  ADDR_SELECT_SIZE = ADDR_SELECT_SIZE_DEF,
  parameter logic [PC_SELECT_SIZE-1:0]    PC_SRC_VEC       = PC_SELECT_SIZE'(mealy_cm_pkg::PC_SRC_VECTOR),
  parameter logic [ADDR_SELECT_SIZE-1:0]  ADDR_SRC_PC_SEL  = ADDR_SELECT_SIZE'(mealy_cm_pkg::ADDR_SRC_PC)
) (
  input  state_e                      state_i,
  input  logic                        reset_i,
  input  logic                        hold_i,
  output logic                        pc_rst_no,
  output logic                        pc_ld_no,
  output logic                        mar_rst_no,
  output logic                        mar_ld_no,
  output logic [PC_SELECT_SIZE-1:0]   pc_src_o,
  output logic [ADDR_SELECT_SIZE-1:0] addr_src_o,
  output logic                        halt_o
);

  always_comb begin
    pc_rst_no  = 1'b1;
    pc_ld_no   = 1'b1;
    mar_rst_no = 1'b1;
    mar_ld_no  = 1'b1;
    pc_src_o   = '0;
    addr_src_o = '0;
    halt_o     = 1'b0;

    if (reset_i) begin
      pc_rst_no  = 1'b0;
      mar_rst_no = 1'b0;
    end else begin
      unique case (state_i)
        S_RESET: begin
          pc_rst_no  = 1'b0;
          mar_rst_no = 1'b0;
        end
        // Selects stay driven during hold so the mux inputs are stable on release.
        S_VECTOR: begin
          pc_src_o = PC_SRC_VEC;
          pc_ld_no = hold_i;
        end
        S_LD_MAR: begin
          addr_src_o = ADDR_SRC_PC_SEL;
          mar_ld_no  = hold_i;
        end
        S_HALT: begin
          halt_o = 1'b1;
        end
        default: begin
          pc_rst_no  = 1'b0;
          mar_rst_no = 1'b0;
        end
      endcase
    end
  end

endmodule : mealy_cm_decode

// File: rtl/mealy_control_matrix.sv
// Reset/boot sequencer: S_RESET -> S_VECTOR -> S_LD_MAR -> S_HALT, stalled by hold_i.
// Optional build macro MEALY_CM_STATE_DBG_EN adds state_dbg_o with the raw state encoding.
module mealy_control_matrix
  import mealy_cm_pkg::*;
#(
  parameter int unsigned                  PC_SELECT_SIZE   = PC_SELECT_SIZE_DEF,
  parameter int unsigned                  ADDR_SELECT_SIZE = ADDR_SELECT_SIZE_DEF,
  parameter logic [PC_SELECT_SIZE-1:0]    PC_SRC_VECTOR    = PC_SELECT_SIZE'(mealy_cm_pkg::PC_SRC_VECTOR),
  parameter logic [ADDR_SELECT_SIZE-1:0]  ADDR_SRC_PC      = ADDR_SELECT_SIZE'(mealy_cm_pkg::ADDR_SRC_PC)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        hold_i,
  output logic                        pc_rst_no,
  output logic                        pc_ld_no,
  output logic                        mar_rst_no,
  output logic                        mar_ld_no,
  output logic [PC_SELECT_SIZE-1:0]   pc_src_o,
  output logic [ADDR_SELECT_SIZE-1:0] addr_src_o,
`ifdef MEALY_CM_STATE_DBG_EN
  output logic [1:0]                  state_dbg_o,
`endif
  output logic                        halt_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_RESET;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_VECTOR;
      S_VECTOR: state_d = hold_i ? S_VECTOR : S_LD_MAR;
      S_LD_MAR: state_d = hold_i ? S_LD_MAR : S_HALT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  mealy_cm_decode #(
    .PC_SELECT_SIZE   (PC_SELECT_SIZE),
    .ADDR_SELECT_SIZE (ADDR_SELECT_SIZE),
    .PC_SRC_VEC       (PC_SRC_VECTOR),
    .ADDR_SRC_PC_SEL  (ADDR_SRC_PC)
  ) u_decode (
    .state_i    (state_q),
    .reset_i    (reset_i),
    .hold_i     (hold_i),
    .pc_rst_no  (pc_rst_no),
    .pc_ld_no   (pc_ld_no),
    .mar_rst_no (mar_rst_no),
    .mar_ld_no  (mar_ld_no),
    .pc_src_o   (pc_src_o),
    .addr_src_o (addr_src_o),
    .halt_o     (halt_o)
  );

`ifdef MEALY_CM_STATE_DBG_EN
  assign state_dbg_o = state_q;
`endif

endmodule : mealy_control_matrix

// File: tb/tb_mealy_control_matrix.sv
// Directed bench for mealy_control_matrix with a small PC/MAR model fed by the strobes.
module tb_mealy_control_matrix;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       hold_i;
  logic       pc_rst_no, pc_ld_no, mar_rst_no, mar_ld_no, halt_o;
  logic [2:0] pc_src_o;
  logic [1:0] addr_src_o;
`ifdef MEALY_CM_STATE_DBG_EN
  logic [1:0] state_dbg_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] pc_m, mar_m;

  always #5 clk_i = ~clk_i;

  mealy_control_matrix dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .hold_i     (hold_i),
    .pc_rst_no  (pc_rst_no),
    .pc_ld_no   (pc_ld_no),
    .mar_rst_no (mar_rst_no),
    .mar_ld_no  (mar_ld_no),
    .pc_src_o   (pc_src_o),
    .addr_src_o (addr_src_o),
`ifdef MEALY_CM_STATE_DBG_EN
    .state_dbg_o(state_dbg_o),
`endif
    .halt_o     (halt_o)
  );

  // Datapath stand-in: vector input is 0xFF, other PC mux inputs give 0x11.
  always @(posedge clk_i or negedge pc_rst_no) begin
    if (!pc_rst_no)     pc_m <= 8'h00;
    else if (!pc_ld_no) pc_m <= (pc_src_o == 3'd2) ? 8'hFF : 8'h11;
  end

  always @(posedge clk_i or negedge mar_rst_no) begin
    if (!mar_rst_no)     mar_m <= 8'h00;
    else if (!mar_ld_no) mar_m <= (addr_src_o == 2'd0) ? pc_m : 8'h33;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs the four strobes and halt: {pc_rst_no, pc_ld_no, mar_rst_no, mar_ld_no, halt_o}
  function automatic logic [31:0] strobes();
    return {27'd0, pc_rst_no, pc_ld_no, mar_rst_no, mar_ld_no, halt_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    reset_i = 1'b1;
    hold_i  = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_strobes", strobes(), 32'b01010);
    end
    check("rst_pc", pc_m, 32'h00);
    check("rst_mar", mar_m, 32'h00);

    reset_i = 1'b0;
    #1;
    check("rst_release_still_reset", strobes(), 32'b01010);

    @(negedge clk_i);
    check("vec_strobes", strobes(), 32'b10110);
    check("vec_pc_src", pc_src_o, 32'd2);

    step();
    check("ldmar_pc", pc_m, 32'hFF);
    check("ldmar_strobes", strobes(), 32'b11100);
    check("ldmar_addr_src", addr_src_o, 32'd0);
    check("ldmar_pc_src", pc_src_o, 32'd0);

    step();
    check("halt_strobes", strobes(), 32'b11111);
    check("halt_mar", mar_m, 32'hFF);

    for (int i = 0; i < 5; i++) begin
      step();
      check("halt_hold_strobes", strobes(), 32'b11111);
    end
    check("halt_mar_kept", mar_m, 32'hFF);

    hold_i = 1'b1;
    step();
    check("halt_ignores_hold", strobes(), 32'b11111);
    hold_i = 1'b0;

    // Restart, then stall two cycles in S_VECTOR
    reset_i = 1'b1;
    #1;
    check("reset_immediate", strobes(), 32'b01010);
    check("reset_pc_cleared", pc_m, 32'h00);
    @(negedge clk_i);
    reset_i = 1'b0;
    step();
    check("vec2_strobes", strobes(), 32'b10110);
    hold_i = 1'b1;
    #1;
    check("vec_hold_no_ld", strobes(), 32'b11110);
    check("vec_hold_pc_src", pc_src_o, 32'd2);
    for (int i = 0; i < 2; i++) begin
      step();
      check("vec_held_state", strobes(), 32'b11110);
      check("vec_held_pc_src", pc_src_o, 32'd2);
    end
    check("vec_held_pc", pc_m, 32'h00);
    hold_i = 1'b0;
    #1;
    check("vec_release_ld", strobes(), 32'b10110);
    step();
    check("ldmar2_strobes", strobes(), 32'b11100);
    check("ldmar2_pc", pc_m, 32'hFF);

    // One stall cycle in S_LD_MAR
    hold_i = 1'b1;
    #1;
    check("ldmar_hold_no_ld", strobes(), 32'b11110);
    step();
    check("ldmar_held_state", strobes(), 32'b11110);
    check("ldmar_held_mar", mar_m, 32'h00);
    hold_i = 1'b0;
    step();
    check("halt2_strobes", strobes(), 32'b11111);
    check("halt2_mar", mar_m, 32'hFF);

    // Pulse reset between clock edges while in S_LD_MAR
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    step();
    step();
    check("ldmar3_strobes", strobes(), 32'b11100);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_strobes", strobes(), 32'b01010);
    check("async_rst_addr_src", addr_src_o, 32'd0);
    check("async_rst_mar", mar_m, 32'h00);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("async_restart_vec", strobes(), 32'b10110);
    check("async_restart_pc_src", pc_src_o, 32'd2);
    step();
    step();
    check("async_restart_halt", strobes(), 32'b11111);
    check("async_restart_mar", mar_m, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mealy_control_matrix
